pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline; successor to the fixed EXE/MEM forwarding logic.
//  Sits beside the ID-stage decoder. Per-operand forwarding selects over N_FWD producer stages, load-use stalls and a store-data bypass.
//  Adds a registered FSM that freezes the pipe on multi-cycle data-memory waits, with a wait timeout.
// PARAMETERS
//  N_FWD       3   producer stages searched for forwarding; index 0 = EXE, 1 = MEM, 2 = WB
//  REG_ADDR_W  5   register address width
//  LOAD_LAT    1   lowest stage index whose load result is forwardable; 1 = MEM output
//  MEM_TMO     255 max MEM_WAIT cycles before mem_timeout is raised; 8-bit counter
// PORTS
//  clk            in   1                 main clock, rising edge
//  rst            in   1                 reset: asynchronous, active-low (0 = reset)
//  rs_addr        in   REG_ADDR_W        ID rs field
//  rt_addr        in   REG_ADDR_W        ID rt field
//  rs_used        in   1                 ID instruction reads rs
//  rt_used        in   1                 ID instruction reads rt
//  is_store       in   1                 ID instruction is a store
//  branch_taken   in   1                 branch/jump resolved taken in ID
//  prod_addr      in   N_FWD*REG_ADDR_W  dest register per stage; stage k = bits [k*W +: W]
//  prod_wen       in   N_FWD             register write enable per stage
//  prod_load      in   N_FWD             stage holds a load
//  mem_req        in   1                 MEM-stage access active this cycle
//  mem_ready      in   1                 data memory completes the access this cycle
//  fwd_a_sel      out  SEL_W             0 = regfile, k+1 = stage k; SEL_W = $clog2(N_FWD+1)
//  fwd_b_sel      out  SEL_W             as fwd_a_sel, for rt
//  fwd_m          out  1                 store-data bypass from the load in stage LOAD_LAT-1
//  if_en, id_en, exe_en, mem_en, wb_en   out 1 each   stage enables
//  id_flush, exe_flush, wb_flush         out 1 each   stage bubble inserts
//  mem_timeout    out  1                 sticky error flag, registered
//  stall_cnt, flush_cnt, wait_cnt        out 32 each  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: while rst=0
//   - state=RUN; wait counter, mem_timeout and perf counters = 0
//   - all *_en=0, all *_flush=1, fwd_*_sel=0, fwd_m=0
//  Forward match, combinational, per operand, operand used and addr!=0:
//   - Search stages 0..N_FWD-1 for prod_wen & prod_addr==addr. Lowest index wins.
//   - No match gives sel=0.
//  Load hazard: winning stage k has prod_load and k<LOAD_LAT.
//   - Exception, no hazard: the operand is rt only, is_store=1 and k==LOAD_LAT-1. Drive fwd_m=1 and fwd_b_sel=0.
//  Forwarding selects are valid only in RUN without hazard. Otherwise they are don't-care and are driven to 0.
//  FSM, state registered, output decode combinational:
//   RUN (normal)
//    - Default outputs: all en=1, all flush=0.
//    - mem_req & !mem_ready: enter MEM_WAIT and apply freeze outputs this same cycle.
//    - Else load hazard: if_en=id_en=0, exe_flush=1. State stays RUN; the stall re-evaluates every cycle.
//    - Else branch_taken: id_flush=1.
//   MEM_WAIT
//    - Outputs: if/id/exe/mem_en=0, wb_flush=1; wait counter +1 per cycle.
//    - mem_ready=1: return to RUN. Enables are released in the same cycle; wait counter cleared.
//    - Counter reaches MEM_TMO: set mem_timeout (sticky until reset) and keep waiting.
//  Priority: memory freeze > load stall > branch flush.
//   - branch_taken during a stall or freeze is ignored; ID re-asserts it once the stall clears.
//  All counters saturate and never wrap.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - stall_cnt counts +1 per load-stall cycle.
//   - flush_cnt counts +1 per id_flush cycle.
//   - wait_cnt counts +1 per MEM_WAIT cycle.
//  Undefined: the three ports stay present, are tied to 0 and no counter flops are built.
// STRUCTURE
//  Shared header hazard_define.vh: FSM encodings HZ_RUN/HZ_MEM_WAIT, FWD_SEL_RF=0, SEL_W macro.
//  Sub-module fwd_match (priority matcher: addr, used, prod_* in; sel, hit_load, hit_idx out), instantiated once for rs and once for rt.
// TESTING
//  1. add $3 in EXE, ID add $4,$3,$3
//     -> fwd_a_sel=fwd_b_sel=1, all en=1, no flush.
//  2. lw $3 in EXE, ID add $4,$3,$0
//     -> one cycle if_en=id_en=0, exe_flush=1; next cycle fwd_a_sel=2.
//  3. lw $5 in EXE, ID sw $5,0($2)
//     -> fwd_m=1, no stall.
//  4. $3 written in EXE and MEM, ID reads $3
//     -> sel=1 (nearest wins); with rs_addr=0 -> sel=0.
//  5. mem_req=1, mem_ready=0 for 3 cycles, then 1
//     -> 3 frozen cycles with wb_flush=1, then RUN; with MEM_TMO=2, mem_timeout=1 from cycle 3.
//  6. Assert rst=0 mid-MEM_WAIT
//     -> outputs take reset values immediately with no clock edge; after release, RUN with counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e  : controller FSM state (normal run / data-memory wait freeze)
//   FWD_SEL_RF  : forwarding select value meaning "use register file"
//   WAIT_CNT_W  : width of the memory-wait timeout counter
//   sel_w()     : width of a forwarding select for a given number of producer stages
package pipe_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      StRun     = 1'b0,
      StMemWait = 1'b1
   } hz_state_e;

   localparam int unsigned FWD_SEL_RF = 0;
   localparam int unsigned WAIT_CNT_W = 8;

   // One code per producer stage plus the register-file code.
   function automatic int unsigned sel_w(input int unsigned n_fwd);
      return $clog2(n_fwd + 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority forwarding matcher for one ID-stage source operand.
// Searches producer stages 0..N_FWD-1 (0 = nearest) for a pending write to the operand's
// register; the nearest stage wins. Register 0 and unused operands never match.
// Ports:
//   addr      in   operand register address
//   used      in   instruction actually reads this operand
//   prod_addr in   destination register per stage, stage k = bits [k*W +: W]
//   prod_wen  in   register write enable per stage
//   prod_load in   stage holds a load
//   sel       out  FWD_SEL_RF on no match, else winning stage index + 1
//   hit_load  out  winning stage holds a load
//   hit_idx   out  winning stage index (0 when no match)
module pipe_hazard_ctrl_fwd_match
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned N_FWD      = 3,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned SEL_W      = 2
) (
   input  logic [REG_ADDR_W-1:0]       addr,
   input  logic                        used,
   input  logic [N_FWD*REG_ADDR_W-1:0] prod_addr,
   input  logic [N_FWD-1:0]            prod_wen,
   input  logic [N_FWD-1:0]            prod_load,
   output logic [SEL_W-1:0]            sel,
   output logic                        hit_load,
   output logic [SEL_W-1:0]            hit_idx
);

   logic hit;

   always_comb begin
      hit      = 1'b0;
      sel      = SEL_W'(FWD_SEL_RF);
      hit_load = 1'b0;
      hit_idx  = '0;
      if (used && (addr != '0)) begin
         for (int i = 0; i < int'(N_FWD); i++) begin
            if (!hit && prod_wen[i] && (prod_addr[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
               hit      = 1'b1;
               sel      = SEL_W'(i + 1);
               hit_load = prod_load[i];
               hit_idx  = SEL_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline, beside the ID decoder.
// Per-operand forwarding over N_FWD producer stages, load-use stalls, store-data bypass, and
// a freeze FSM for multi-cycle data-memory accesses with a sticky wait timeout.
// Optional feature macro: HAZARD_PERF_CNT_EN builds the stall/flush/wait perf counters;
// without it the counter ports are tied to 0.
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   rs_addr/rt_addr, rs_used/rt_used, is_store, branch_taken   ID-stage instruction info
//   prod_addr/prod_wen/prod_load  per-stage producer info, stage 0 = EXE
//   mem_req/mem_ready             MEM-stage access request and completion
//   fwd_a_sel/fwd_b_sel/fwd_m     forwarding selects and store-data bypass
//   *_en / *_flush                stage enables and bubble inserts
//   mem_timeout                   sticky wait-timeout flag (registered)
//   stall_cnt/flush_cnt/wait_cnt  saturating perf counters
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned N_FWD      = 3,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned MEM_TMO    = 255,
   localparam int unsigned SEL_W     = sel_w(N_FWD)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [REG_ADDR_W-1:0]       rs_addr,
   input  logic [REG_ADDR_W-1:0]       rt_addr,
   input  logic                        rs_used,
   input  logic                        rt_used,
   input  logic                        is_store,
   input  logic                        branch_taken,
   input  logic [N_FWD*REG_ADDR_W-1:0] prod_addr,
   input  logic [N_FWD-1:0]            prod_wen,
   input  logic [N_FWD-1:0]            prod_load,
   input  logic                        mem_req,
   input  logic                        mem_ready,
   output logic [SEL_W-1:0]            fwd_a_sel,
   output logic [SEL_W-1:0]            fwd_b_sel,
   output logic                        fwd_m,
   output logic                        if_en,
   output logic                        id_en,
   output logic                        exe_en,
   output logic                        mem_en,
   output logic                        wb_en,
   output logic                        id_flush,
   output logic                        exe_flush,
   output logic                        wb_flush,
   output logic                        mem_timeout,
   output logic [31:0]                 stall_cnt,
   output logic [31:0]                 flush_cnt,
   output logic [31:0]                 wait_cnt
);

   hz_state_e             state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_q, wait_d;
   logic                  tmo_q, tmo_d;

   logic [SEL_W-1:0] a_sel, b_sel, a_idx, b_idx;
   logic             a_load, b_load;
   logic             hz_a, hz_b, store_byp, load_hz, freeze, fwd_ok;

   pipe_hazard_ctrl_fwd_match #(
      .N_FWD      (N_FWD),
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W)
   ) u_match_rs (
      .addr      (rs_addr),
      .used      (rs_used),
      .prod_addr (prod_addr),
      .prod_wen  (prod_wen),
      .prod_load (prod_load),
      .sel       (a_sel),
      .hit_load  (a_load),
      .hit_idx   (a_idx)
   );

   pipe_hazard_ctrl_fwd_match #(
      .N_FWD      (N_FWD),
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W)
   ) u_match_rt (
      .addr      (rt_addr),
      .used      (rt_used),
      .prod_addr (prod_addr),
      .prod_wen  (prod_wen),
      .prod_load (prod_load),
      .sel       (b_sel),
      .hit_load  (b_load),
      .hit_idx   (b_idx)
   );

   always_comb begin
      hz_a      = a_load && (int'(a_idx) < int'(LOAD_LAT));
      hz_b      = b_load && (int'(b_idx) < int'(LOAD_LAT));
      // A store only needs rt at MEM, so a load one stage ahead is bypassed there instead.
      store_byp = hz_b && is_store && (int'(b_idx) == int'(LOAD_LAT) - 1);
      load_hz   = hz_a || (hz_b && !store_byp);
      // Freeze on the cycle the wait starts and for every wait cycle until mem_ready.
      freeze    = !mem_ready && ((state_q == StMemWait) || mem_req);
      // The release cycle of a wait advances the pipe, so selects must be valid then too.
      fwd_ok    = ((state_q == StRun) || mem_ready) && !load_hz;
   end

   // Output decode; reset overrides combinationally so it acts without a clock edge.
   always_comb begin
      if_en     = 1'b1;
      id_en     = 1'b1;
      exe_en    = 1'b1;
      mem_en    = 1'b1;
      wb_en     = 1'b1;
      id_flush  = 1'b0;
      exe_flush = 1'b0;
      wb_flush  = 1'b0;
      fwd_a_sel = SEL_W'(FWD_SEL_RF);
      fwd_b_sel = SEL_W'(FWD_SEL_RF);
      fwd_m     = 1'b0;
      if (!rst) begin
         if_en     = 1'b0;
         id_en     = 1'b0;
         exe_en    = 1'b0;
         mem_en    = 1'b0;
         wb_en     = 1'b0;
         id_flush  = 1'b1;
         exe_flush = 1'b1;
         wb_flush  = 1'b1;
      end else begin
         if (freeze) begin
            if_en    = 1'b0;
            id_en    = 1'b0;
            exe_en   = 1'b0;
            mem_en   = 1'b0;
            wb_flush = 1'b1;
         end else if (load_hz) begin
            if_en     = 1'b0;
            id_en     = 1'b0;
            exe_flush = 1'b1;
         end else if (branch_taken) begin
            id_flush = 1'b1;
         end
         if (fwd_ok) begin
            fwd_a_sel = a_sel;
            fwd_b_sel = store_byp ? SEL_W'(FWD_SEL_RF) : b_sel;
            fwd_m     = store_byp;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:     if (mem_req && !mem_ready) state_d = StMemWait;
         StMemWait: if (mem_ready) state_d = StRun;
         default:   state_d = StRun;
      endcase
      // Counts frozen cycles including the entry cycle; saturates.
      if (freeze) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
      end else begin
         wait_d = '0;
      end
      tmo_d = tmo_q || (freeze && (wait_d >= WAIT_CNT_W'(MEM_TMO)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StRun;
         wait_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
      end
   end

   assign mem_timeout = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q, flush_q, wcnt_q;
   logic        stall_cyc;

   assign stall_cyc = !freeze && load_hz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
         wcnt_q  <= '0;
      end else begin
         if (stall_cyc && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (id_flush && (flush_q != '1)) flush_q <= flush_q + 32'd1;
         if ((state_q == StMemWait) && (wcnt_q != '1)) wcnt_q <= wcnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
   assign wait_cnt  = wcnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver applies directed then random stimulus
// shortly after each rising edge and pushes the reference model's expectation; the monitor
// pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;
   localparam int NF  = 3;
   localparam int W   = 5;
   localparam int LL  = 1;
   localparam int TMO = 3;
   localparam int SW  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [W-1:0]    rs_addr, rt_addr;
   logic            rs_used, rt_used, is_store, branch_taken;
   logic [NF*W-1:0] prod_addr;
   logic [NF-1:0]   prod_wen, prod_load;
   logic            mem_req, mem_ready;
   logic [SW-1:0]   fwd_a_sel, fwd_b_sel;
   logic            fwd_m, if_en, id_en, exe_en, mem_en, wb_en;
   logic            id_flush, exe_flush, wb_flush, mem_timeout;
   logic [31:0]     stall_cnt, flush_cnt, wait_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .N_FWD      (NF),
      .REG_ADDR_W (W),
      .LOAD_LAT   (LL),
      .MEM_TMO    (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_used      (rs_used),
      .rt_used      (rt_used),
      .is_store     (is_store),
      .branch_taken (branch_taken),
      .prod_addr    (prod_addr),
      .prod_wen     (prod_wen),
      .prod_load    (prod_load),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .fwd_m        (fwd_m),
      .if_en        (if_en),
      .id_en        (id_en),
      .exe_en       (exe_en),
      .mem_en       (mem_en),
      .wb_en        (wb_en),
      .id_flush     (id_flush),
      .exe_flush    (exe_flush),
      .wb_flush     (wb_flush),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .wait_cnt     (wait_cnt)
   );

   typedef struct {
      logic [SW-1:0] a_sel;
      logic [SW-1:0] b_sel;
      logic          fm;
      logic [4:0]    en;   // {if, id, exe, mem, wb}
      logic [2:0]    fl;   // {id, exe, wb}
      logic          tmo;
      logic [31:0]   sc, fc, wc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   drv_done = 1'b0;

   // Reference model state: waiting flag, frozen-cycle count, sticky timeout, perf counts.
   bit          m_wait, m_tmo;
   int          m_wcnt;
   int unsigned m_sc, m_fc, m_wc;

   function automatic int find_src(input logic [W-1:0] a, input logic u);
      if (!u || a == '0) return -1;
      for (int k = 0; k < NF; k++) begin
         if (prod_wen[k] && prod_addr[k*W +: W] == a) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_wait = 1'b0; m_tmo = 1'b0; m_wcnt = 0;
      m_sc = 0; m_fc = 0; m_wc = 0;
   endtask

   // Predict this cycle's outputs, queue them, then advance the model across the next edge.
   task automatic step();
      exp_t e;
      int   ka, kb;
      bit   hza, hzb, byp, hz, frz, run;
      if (!rst) begin
         model_reset();
         e = '{a_sel: '0, b_sel: '0, fm: 1'b0, en: 5'b00000, fl: 3'b111, tmo: 1'b0,
               sc: 32'd0, fc: 32'd0, wc: 32'd0};
         sb.push_back(e);
         return;
      end
      ka  = find_src(rs_addr, rs_used);
      kb  = find_src(rt_addr, rt_used);
      hza = (ka >= 0) && prod_load[ka] && (ka < LL);
      hzb = (kb >= 0) && prod_load[kb] && (kb < LL);
      byp = hzb && is_store && (kb == LL - 1);
      hz  = hza || (hzb && !byp);
      frz = !mem_ready && (m_wait || mem_req);
      run = !m_wait || mem_ready;
      e.a_sel = (run && !hz && ka >= 0) ? SW'(ka + 1) : '0;
      e.b_sel = (run && !hz && kb >= 0 && !byp) ? SW'(kb + 1) : '0;
      e.fm    = run && !hz && byp;
      e.en    = 5'b11111;
      e.fl    = 3'b000;
      if (frz) begin
         e.en = 5'b00001; e.fl = 3'b001;
      end else if (hz) begin
         e.en = 5'b00111; e.fl = 3'b010;
      end else if (branch_taken) begin
         e.fl = 3'b100;
      end
      e.tmo = m_tmo;
`ifdef HAZARD_PERF_CNT_EN
      e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
`else
      e.sc = 0; e.fc = 0; e.wc = 0;
`endif
      sb.push_back(e);
      if (!frz && hz && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (!frz && !hz && branch_taken && m_fc != 32'hFFFF_FFFF) m_fc++;
      if (m_wait && m_wc != 32'hFFFF_FFFF) m_wc++;
      if (frz) begin
         if (m_wcnt < 255) m_wcnt++;
         if (m_wcnt >= TMO) m_tmo = 1'b1;
      end else begin
         m_wcnt = 0;
      end
      m_wait = m_wait ? !mem_ready : (mem_req && !mem_ready);
   endtask

   task automatic tick();
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
      is_store = 1'b0; branch_taken = 1'b0;
      prod_addr = '0; prod_wen = '0; prod_load = '0;
      mem_req = 1'b0; mem_ready = 1'b1;
   endtask

   task automatic set_prod(input int k, input int a, input bit wen, input bit ld);
      prod_addr[k*W +: W] = W'(a);
      prod_wen[k]         = wen;
      prod_load[k]        = ld;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: one comparison set per queued expectation, sampled mid-cycle.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.a_sel));
            chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.b_sel));
            chk("fwd_m", 32'(fwd_m), 32'(e.fm));
            chk("enables", 32'({if_en, id_en, exe_en, mem_en, wb_en}), 32'(e.en));
            chk("flushes", 32'({id_flush, exe_flush, wb_flush}), 32'(e.fl));
            chk("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
            chk("wait_cnt", wait_cnt, e.wc);
         end
         if (drv_done && sb.size() == 0) break;
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of run, expected end before time limit");
      $fatal(1, "bench time limit expired");
   end

   initial begin : driver
      rst = 1'b0;
      idle();
      model_reset();
      @(posedge clk); #1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      // add $3 in EXE; add $4,$3,$3 -> both operands from EXE
      set_prod(0, 3, 1, 0);
      rs_addr = 3; rt_addr = 3; rs_used = 1; rt_used = 1;
      tick();
      // lw $3 in EXE; add $4,$3,$0 -> stall, then forward from MEM
      idle(); set_prod(0, 3, 1, 1);
      rs_addr = 3; rs_used = 1; rt_used = 1;
      tick();
      set_prod(0, 0, 0, 0); set_prod(1, 3, 1, 1);
      tick();
      // lw $5 in EXE; sw $5,0($2) -> store-data bypass, no stall
      idle(); set_prod(0, 5, 1, 1);
      rs_addr = 2; rs_used = 1; rt_addr = 5; rt_used = 1; is_store = 1;
      tick();
      // $3 in EXE and MEM -> nearest wins; rs=$0 never forwards
      idle(); set_prod(0, 3, 1, 0); set_prod(1, 3, 1, 0);
      rs_addr = 3; rs_used = 1;
      tick();
      rs_addr = 0;
      tick();
      // branch with no hazard
      idle(); branch_taken = 1;
      tick();
      // memory wait: 4 stalled cycles reaches the timeout, then release
      idle(); mem_req = 1; mem_ready = 0; branch_taken = 1;
      repeat (4) tick();
      mem_ready = 1;
      tick();
      idle();
      tick();
      // async reset in the middle of a wait
      mem_req = 1; mem_ready = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1; idle();
      tick();
      // random phase
      for (int n = 0; n < 500; n++) begin
         rs_addr      = W'($urandom_range(0, 3));
         rt_addr      = W'($urandom_range(0, 3));
         rs_used      = 1'($urandom_range(0, 1));
         rt_used      = 1'($urandom_range(0, 1));
         is_store     = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < NF; k++) begin
            set_prod(k, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0));
         end
         if (m_wait) begin
            mem_req   = 1'b1;
            mem_ready = ($urandom_range(0, 2) == 0);
         end else begin
            mem_req   = ($urandom_range(0, 4) == 0);
            mem_ready = 1'($urandom_range(0, 1));
         end
         rst = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst = 1'b1;
      drv_done = 1'b1;
   end

endmodule
